inst_fetch_unit: RTL and testbench



---
 rtl/inst_fetch_unit.sv | 86 ++++++++
 tb/tb_inst_fetch_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC, one-read-per-instruction fetch FSM, instruction register and decode strobe.
// Optional FETCH_TIMEOUT_EN adds a wait-cycle limit that abandons a stuck fetch and pulses fetch_err.
module inst_fetch_unit #(
    parameter int                    ADDR_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter int                    TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_valid,
    output logic [15:0]           instruction,
    output logic                  decode,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  fetch_err
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DECODE, S_HOLD} state_t;
    state_t state;
    logic   squash;
    logic   timeout;
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    assign timeout = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else
            wait_cnt <= (state == S_WAIT && !mem_valid && !timeout) ? wait_cnt + CW'(1) : '0;
    end
`else
    assign timeout = 1'b0;
`endif
    // mem_rd is gated by rst_n so no request is visible while reset is held
    assign mem_rd    = rst_n && (state == S_FETCH);
    assign decode    = (state == S_DECODE);
    assign mem_addr  = pc;
    assign fetch_err = timeout;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instruction <= 16'h0000;
            squash      <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    state <= S_WAIT;
                    if (branch_taken) begin
                        pc     <= branch_target;
                        squash <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (timeout) begin
                        state  <= S_FETCH;
                        squash <= 1'b0;
                        if (branch_taken) pc <= branch_target;
                    end else if (mem_valid) begin
                        squash <= 1'b0;
                        if (branch_taken) pc <= branch_target;
                        if (!squash && !branch_taken) instruction <= mem_rdata;
                        state <= (squash || branch_taken) ? S_FETCH : S_DECODE;
                    end else if (branch_taken) begin
                        pc     <= branch_target;
                        squash <= 1'b1;
                    end
                end
                S_DECODE: begin
                    pc    <= branch_taken ? branch_target : pc + ADDR_WIDTH'(1);
                    state <= (stall && !branch_taken) ? S_HOLD : S_FETCH;
                end
                S_HOLD: begin
                    if (branch_taken) pc <= branch_target;
                    if (!stall || branch_taken) state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed and random stimulus against an event-level fetch model
// (expected fetch address, outstanding/stale request, pending decode) with a behavioural memory.
module tb_inst_fetch_unit;
    logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, branch_taken = 1'b0, mem_valid = 1'b0;
    logic [7:0]  branch_target = '0, mem_addr, pc;
    logic [15:0] mem_rdata = '0, instruction;
    logic        mem_rd, decode, fetch_err;
    int          checks = 0, failures = 0;

    logic [15:0] mem [256];
    bit          rd_due, dec_due, outstanding, stale, holding;
    int          wait_cnt;
    logic [7:0]  nf, req_addr;
    logic [15:0] ir;

    always #5 clk = ~clk;

    inst_fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(8'h00), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .instruction(instruction),
        .decode(decode), .pc(pc), .fetch_err(fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        rd_due = 1; dec_due = 0; outstanding = 0; stale = 0; holding = 0;
        wait_cnt = 0; nf = 8'h00; req_addr = 8'h00; ir = 16'h0000;
    endtask

    task automatic check_reset();
        check("rst_mem_rd", mem_rd, 0);
        check("rst_decode", decode, 0);
        check("rst_pc", pc, 0);
        check("rst_instruction", instruction, 0);
        check("rst_fetch_err", fetch_err, 0);
    endtask

    // one clock cycle: check outputs, drive inputs, advance the model; lat = extra wait cycles of a fetch issued now
    task automatic step(input bit st, input bit br, input logic [7:0] tgt, input int lat);
        bit rd, dec, vnow;
        #1;
        rd  = rd_due;
        dec = dec_due;
        check("mem_rd", mem_rd, rd);
        check("decode", decode, dec);
        check("fetch_err", fetch_err, 0);
        check("instruction", instruction, ir);
        if (rd) begin
            check("mem_addr", mem_addr, nf);
            check("pc_at_fetch", pc, nf);
        end
        if (dec) check("pc_at_decode", pc, req_addr);
        vnow = outstanding && wait_cnt == 0;
        if (outstanding && wait_cnt > 0) wait_cnt--;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        mem_valid     = vnow;
        mem_rdata     = vnow ? mem[req_addr] : 16'($urandom);
        rd_due  = 0;
        dec_due = 0;
        if (vnow) begin
            outstanding = 0;
            if (stale || br) rd_due = 1;
            else begin
                dec_due = 1;
                ir      = mem[req_addr];
            end
            stale = 0;
        end
        if (rd) begin
            outstanding = 1;
            stale       = 0;
            wait_cnt    = lat;
            req_addr    = nf;
        end
        if (br) begin
            nf = tgt;
            if (outstanding) stale = 1;
            if (dec || holding) rd_due = 1;
            holding = 0;
        end
        if (holding && !st) begin
            holding = 0;
            rd_due  = 1;
        end
        if (dec && !br) begin
            nf = nf + 8'd1;
            if (st) holding = 1;
            else rd_due = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        int guard;
        foreach (mem[i]) mem[i] = 16'($urandom);
        mem[8'h00] = 16'h1234;
        mem[8'h01] = 16'hABCD;
        mem[8'h02] = 16'hDEAD;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // first fetch: addr 0, zero-wait memory, decode on the third cycle
        repeat (3) step(0, 0, 8'h00, 0);
        // decode of 16'hABCD under a 5-cycle stall
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        repeat (5) step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        // branch to 0x40 while waiting; 16'hDEAD arrives two cycles after the request and is dropped
        step(0, 0, 8'h00, 1);
        step(0, 1, 8'h40, 0);
        step(0, 0, 8'h00, 0);
        // fetch at 0x40, then branch to 0x10 in the same cycle as mem_valid
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h10, 0);
        // fetch at 0x10, branch to 0xFE during its decode, then run across the wrap
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'hFE, 0);
        repeat (10) step(0, 0, 8'h00, 0);
        // silent memory: no timeout in this build, the fetch simply waits
        guard = 0;
        while (!rd_due && guard < 10) begin
            step(0, 0, 8'h00, 0);
            guard++;
        end
        check("silent_setup", rd_due, 1);
        step(0, 0, 8'h00, 40);
        repeat (45) step(0, 0, 8'h00, 0);
        repeat (1500) step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, 8'($urandom), $urandom_range(0, 3));
        // asynchronous reset in the middle of traffic
        rst_n = 1'b0;
        #1;
        check_reset();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (400) step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, 8'($urandom), $urandom_range(0, 3));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
